// File: rtl/guess_player.sv
// Binary-search player for the decision comparator: issues guesses on out_wr and narrows
// [lo,hi] from the verdict on result. Optional game statistics ports under GUESS_STATS_EN.
module guess_player #(
  parameter int W          = 2,
  parameter int RESULT_LAT = 1,
  parameter int TIMEOUT    = 4,
  parameter int CW         = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    result,
  output logic [W-1:0]  out_wr,
  output logic          guess_valid,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [CW-1:0] guess_count
`ifdef GUESS_STATS_EN
  ,
  output logic [7:0]    games_played,
  output logic [7:0]    games_won
`endif
);

  localparam int         WCW      = $clog2(RESULT_LAT + 1);
  localparam int         TCW      = $clog2(TIMEOUT + 1);
  localparam logic [W:0] HI_INIT  = {1'b0, {W{1'b1}}};
  localparam logic [W:0] ONE      = (W+1)'(1);
  localparam logic [W-1:0] MID_INIT = HI_INIT[W:1];

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_END
  } state_t;

  state_t         state_q;
  logic [W:0]     lo_q, hi_q;
  logic [W-1:0]   guess_q;
  logic           gv_q, busy_q, done_q, found_q;
  logic [CW-1:0]  cnt_q;
  logic [WCW-1:0] wait_q;
  logic [TCW-1:0] tmo_q;
`ifdef GUESS_STATS_EN
  logic [7:0]     played_q, won_q;
`endif

  logic [W:0]     guess_ext, lo_up_d, hi_dn_d, sum_up, sum_dn;
  logic [W-1:0]   mid_up_d, mid_dn_d;
  logic           up_end, dn_end;
  logic [CW-1:0]  cnt_d;

  // Candidate next range/guess for each verdict; the FSM picks one in CHECK.
  always_comb begin
    guess_ext = {1'b0, guess_q};
    lo_up_d   = guess_ext + ONE;
    hi_dn_d   = guess_ext - ONE;
    sum_up    = lo_up_d + hi_q;
    sum_dn    = lo_q + hi_dn_d;
    mid_up_d  = sum_up[W:1];
    mid_dn_d  = sum_dn[W:1];
    up_end    = (lo_up_d > hi_q);
    dn_end    = (guess_q == '0) || (hi_dn_d < lo_q);
    cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= HI_INIT;
      guess_q  <= '0;
      gv_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      cnt_q    <= '0;
      wait_q   <= '0;
      tmo_q    <= '0;
`ifdef GUESS_STATS_EN
      played_q <= '0;
      won_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            lo_q    <= '0;
            hi_q    <= HI_INIT;
            found_q <= 1'b0;
            busy_q  <= 1'b1;
            guess_q <= MID_INIT;
            gv_q    <= 1'b1;
            cnt_q   <= CW'(1);
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == WCW'(RESULT_LAT - 1)) begin
            tmo_q   <= '0;
            state_q <= S_CHECK;
          end else begin
            wait_q <= wait_q + WCW'(1);
          end
        end
        S_CHECK: begin
          case (result)
            2'b00: begin
              found_q <= 1'b1;
              gv_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_END;
            end
            2'b01: begin
              if (up_end) begin
                gv_q    <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_END;
              end else begin
                lo_q    <= lo_up_d;
                guess_q <= mid_up_d;
                cnt_q   <= cnt_d;
                state_q <= S_ISSUE;
              end
            end
            2'b10: begin
              if (dn_end) begin
                gv_q    <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_END;
              end else begin
                hi_q    <= hi_dn_d;
                guess_q <= mid_dn_d;
                cnt_q   <= cnt_d;
                state_q <= S_ISSUE;
              end
            end
            default: begin
              // No verdict yet: keep the guess up until the timeout budget runs out.
              if (tmo_q == TCW'(TIMEOUT - 1)) begin
                gv_q    <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_END;
              end else begin
                tmo_q <= tmo_q + TCW'(1);
              end
            end
          endcase
        end
        S_END: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
`ifdef GUESS_STATS_EN
          played_q <= played_q + 8'd1;
          if (found_q) won_q <= won_q + 8'd1;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_wr      = guess_q;
  assign guess_valid = gv_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign guess_count = cnt_q;
`ifdef GUESS_STATS_EN
  assign games_played = played_q;
  assign games_won    = won_q;
`endif

endmodule

// File: tb/tb_guess_player.sv
// Randomized bench for guess_player: a latency-accurate comparator drives result and a
// plain binary-search model predicts guesses, count, found and game latency.
module tb_guess_player;
  localparam int W   = 2;
  localparam int RL  = 1;
  localparam int TMO = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    result;
  logic [W-1:0]  out_wr;
  logic          guess_valid, busy, done, found;
  logic [CW-1:0] guess_count;
`ifdef GUESS_STATS_EN
  logic [7:0]    games_played, games_won;
`endif

  guess_player #(.W(W), .RESULT_LAT(RL), .TIMEOUT(TMO), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .result(result),
    .out_wr(out_wr), .guess_valid(guess_valid), .busy(busy), .done(done),
    .found(found), .guess_count(guess_count)
`ifdef GUESS_STATS_EN
    , .games_played(games_played), .games_won(games_won)
`endif
  );

  always #5 clk = ~clk;

  // mode 0: real comparator; 1: always 01; 2: always 11; 3: always 10
  int mode, secret;
  logic [1:0] pipe [RL];

  function automatic logic [1:0] verdict(input int g);
    case (mode)
      1:       return 2'b01;
      2:       return 2'b11;
      3:       return 2'b10;
      default: return (g == secret) ? 2'b00 : ((g < secret) ? 2'b01 : 2'b10);
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RL; i++) pipe[i] <= 2'b11;
    end else begin
      pipe[0] <= guess_valid ? verdict(int'(out_wr)) : 2'b11;
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign result = pipe[RL-1];

  int checks = 0, fails = 0;
  int exp_q[$];
  int exp_found, exp_lat;
  int m_played = 0, m_won = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model(input int md, input int sec);
    int lo, hi, g, v;
    lo = 0; hi = (1 << W) - 1; v = 0;
    exp_q = {}; exp_found = 0;
    forever begin
      g = (lo + hi) / 2;
      exp_q.push_back(g);
      case (md)
        1: v = 1;
        2: v = 3;
        3: v = 2;
        default: v = (g == sec) ? 0 : ((g < sec) ? 1 : 2);
      endcase
      if (v == 0) begin exp_found = 1; break; end
      if (v == 3) break;
      if (v == 1) begin
        lo = g + 1;
        if (lo > hi) break;
      end else begin
        if (g == 0 || g - 1 < lo) break;
        hi = g - 1;
      end
    end
    exp_lat = (v == 3) ? (RL + 1 + TMO) : exp_q.size() * (RL + 2);
  endtask

  task automatic play(input int md, input int sec, input bit extra);
    int edges, bad_busy, ncnt;
    int got_q[$];
    logic pgv;
    logic [W-1:0] pg;
    bit seen_done;
    mode = md; secret = sec;
    model(md, sec);
    @(negedge clk);
    start = 1'b1;
    edges = 0; bad_busy = 0; pgv = 1'b0; pg = '0; seen_done = 1'b0;
    while (edges < 200) begin
      @(negedge clk);
      edges++;
      start = (extra && edges == 2);
      if (guess_valid && (!pgv || out_wr != pg)) got_q.push_back(int'(out_wr));
      pgv = guess_valid; pg = out_wr;
      if (done) begin seen_done = 1'b1; break; end
      if (!busy) bad_busy++;
    end
    start = 1'b0;
    ncnt = (exp_q.size() > (1 << CW) - 1) ? (1 << CW) - 1 : exp_q.size();
    chk("done_seen", int'(seen_done), 1);
    chk("latency", edges, exp_lat + 1);
    chk("busy_mid", bad_busy, 0);
    chk("found", int'(found), exp_found);
    chk("guess_count", int'(guess_count), ncnt);
    chk("n_guesses", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("guess%0d", i), got_q[i], exp_q[i]);
    chk("busy_end", int'(busy), 0);
    chk("gv_end", int'(guess_valid), 0);
    @(negedge clk);
    chk("done_pulse", int'(done), 0);
    chk("hold_guess", int'(out_wr), exp_q[exp_q.size()-1]);
    chk("hold_count", int'(guess_count), ncnt);
    chk("gv_idle", int'(guess_valid), 0);
    m_played = (m_played + 1) % 256;
    if (exp_found == 1) m_won = (m_won + 1) % 256;
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; mode = 0; secret = 0;
    #12;
    chk("rst_out_wr", int'(out_wr), 0);
    chk("rst_gv", int'(guess_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_found", int'(found), 0);
    chk("rst_count", int'(guess_count), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    play(0, 2, 1'b0);
    play(0, 0, 1'b0);
    play(0, 3, 1'b0);
    play(1, 0, 1'b0);
    play(2, 0, 1'b1);
    play(3, 0, 1'b0);

    // Reset during WAIT aborts with no done pulse.
    mode = 0; secret = 3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_out_wr", int'(out_wr), 0);
    chk("arst_gv", int'(guess_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_found", int'(found), 0);
    chk("arst_count", int'(guess_count), 0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (done) ndone++;
    chk("arst_no_done", ndone, 0);
    m_played = 0; m_won = 0;
    play(0, 1, 1'b0);
`ifdef GUESS_STATS_EN
    chk("stats_played", int'(games_played), 1);
    chk("stats_won", int'(games_won), 1);
`endif

    for (int n = 0; n < 30; n++) begin
      int md;
      md = $urandom_range(0, 6);
      if (md > 3) md = 0;
      play(md, $urandom_range(0, (1 << W) - 1), 1'($urandom_range(0, 1)));
    end
`ifdef GUESS_STATS_EN
    chk("stats_played_end", int'(games_played), m_played);
    chk("stats_won_end", int'(games_won), m_won);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/guess_player.md
Name: guess_player

Overview:
- Automatic player that drives the guess side of the `decision` comparator.
- Issues a W-bit guess on `out_wr` and reads back the 2-bit verdict on `result`.
- Narrows the range by binary search until the verdict reports a match.
- Sits opposite `decision` in the guessing-game datapath; the secret value (`Correct_guess`) is held elsewhere.

Parameters:
- W, 2, guess/secret width in bits (matches `decision` port width).
- RESULT_LAT, 1, clock cycles from guess presentation to a valid verdict on `result` (≥1).
- TIMEOUT, 4, extra sample cycles tolerated while `result`=2'b11 before aborting (≥1).
- CW, 4, width of `guess_count`; must hold W+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a game; ignored while `busy`=1.
- result  input  2  verdict encoding:
  - 00 = match
  - 01 = guess below secret
  - 10 = guess above secret
  - 11 = no verdict
- out_wr  output  W  current guess.
- guess_valid  output  1  high while `out_wr` is being judged.
- busy  output  1  game in progress.
- done  output  1  one-cycle pulse at game end.
- found  output  1  sticky; 1 = last game ended on a match; cleared by `start`.
- guess_count  output  CW  number of guesses issued in the current or last game; saturates at all-ones.

Behaviour:
- Reset (async, `rst_n`=0):
  - state=IDLE.
  - `out_wr`=0, `guess_valid`=0, `busy`=0, `done`=0, `found`=0, `guess_count`=0.
  - Internal lo=0, hi=2^W−1. Both are (W+1)-bit, so lo may reach 2^W.
- Reset asserted mid-game aborts immediately. No `done` pulse is produced.
- States: IDLE, ISSUE, WAIT, CHECK, END.
- IDLE:
  - On `start`: lo=0, hi=2^W−1, `guess_count`=0, `found`=0, `busy`=1 → ISSUE.
- ISSUE (1 cycle):
  - `out_wr`=(lo+hi)>>1, computed at W+1 bits and truncated to W.
  - `guess_valid`=1; `guess_count`+=1 (saturating) → WAIT.
- WAIT:
  - `guess_valid` and `out_wr` are held stable.
  - A wait counter counts RESULT_LAT cycles, then → CHECK.
- CHECK: `result` is sampled on each edge in this state.
  - 00: `found`=1 → END.
  - 01: lo=guess+1. If lo>hi → END with `found`=0; else → ISSUE.
  - 10: if guess==0 or guess−1<lo → END with `found`=0; else hi=guess−1 → ISSUE.
  - 11: stay in CHECK, with guess still held and a timeout counter incremented. When the counter reaches TIMEOUT → END with `found`=0.
- END (1 cycle): `done`=1, `guess_valid`=0, `busy`=0 → IDLE.
- `out_wr` and `guess_count` keep their last values after END until the next `start`.
- `guess_valid` is 0 in IDLE and END.
- `start` while `busy`=1 is ignored. `start` in the same cycle as END's `done` is also ignored; it is accepted only in IDLE.
- Bound: a consistent comparator yields a match within W+1 guesses.
- Per-guess latency: ISSUE to CHECK sample = RESULT_LAT+1 cycles.

Optional Feature:
- Macro: GUESS_STATS_EN.
- Defined:
  - Adds output ports `games_played` [7:0] and `games_won` [7:0], both reset to 0.
  - `games_played` increments on every `done`.
  - `games_won` increments on `done` with `found`=1.
  - Both wrap at 255→0.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- W=2, comparator model with secret=2 → guesses 1 (verdict 01), then 2 (verdict 00); `found`=1, `guess_count`=2, one `done` pulse.
- Secret=0 → guesses 1 (verdict 10), then 0 (verdict 00); `found`=1, `guess_count`=2.
- Secret=3 → guesses 1, 2, 3 (verdicts 01, 01, 00); `found`=1, `guess_count`=3.
- `result` forced to 01 → guesses 1, 2, 3, then lo=4>hi → `done` with `found`=0, `guess_count`=3.
- `result` forced to 11 with TIMEOUT=4 → single guess 1, `done` after 4 CHECK cycles, `found`=0. A second `start` pulse during WAIT is ignored.
- `rst_n` pulsed low during WAIT → all outputs 0 asynchronously, no `done`. A following `start` with secret=1 ends after 1 guess with `found`=1. With GUESS_STATS_EN defined, `games_played`=1 and `games_won`=1.
